// File: rtl/game_pkg.sv
// Shared types and constants for the Whack-a-Mole round sequencer, display and mole generator.
package game_pkg;

  localparam int unsigned SCORE_W = 10;
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned TIMER_W = 7;

  localparam int unsigned GAME_ROUND_SECS = 60;
  localparam int unsigned GAME_SCORE_MAX  = 99;

  localparam logic [LEVEL_W-1:0] LVL_NONE = 2'd0;
  localparam logic [LEVEL_W-1:0] LVL_1    = 2'd1;
  localparam logic [LEVEL_W-1:0] LVL_2    = 2'd2;
  localparam logic [LEVEL_W-1:0] LVL_3    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_OVER   = 2'd2,
    ST_PAUSED = 2'd3
  } game_state_e;

  // Difficulty level implied by a score within a round.
  function automatic logic [LEVEL_W-1:0] level_of(input logic [SCORE_W-1:0] s,
                                                  input int unsigned lvl2,
                                                  input int unsigned lvl3);
    if (s >= SCORE_W'(lvl3))      return LVL_3;
    else if (s >= SCORE_W'(lvl2)) return LVL_2;
    else                           return LVL_1;
  endfunction

endpackage

// File: rtl/game_round_ctrl_sec_tick_gen.sv
// sec_tick_gen: game-second prescaler with enable and clear; o_wrap_c flags the wrapping edge.
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last   = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_wrap_c = i_en && !i_clr && w_last;

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: game FSM, 1 s tick, elapsed timer, score and level.
// Optional pause feature enabled by defining GAME_PAUSE_EN.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned ROUND_SECS = GAME_ROUND_SECS,
  parameter int unsigned LVL2_SCORE = 10,
  parameter int unsigned LVL3_SCORE = 25,
  parameter int unsigned SCORE_MAX  = GAME_SCORE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               pause,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic [TIMER_W-1:0] timer,
  output logic               sec_tick,
  output logic               playing,
  output logic               game_over
);

  game_state_e        r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [LEVEL_W-1:0] r_level, w_level_nxt;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic               r_tick, w_tick_nxt;
  logic               r_playing, r_over;
  logic               w_pause_req, w_start_play, w_presc_en, w_wrap, w_last_sec;

`ifdef GAME_PAUSE_EN
  assign w_pause_req = pause;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_pause_req    = 1'b0;
`endif

  assign w_start_play = start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
  // The pausing edge itself does not advance the prescaler.
  assign w_presc_en   = (r_state == ST_PLAY) && !w_pause_req;
  assign w_last_sec   = (r_timer == TIMER_W'(ROUND_SECS - 1));

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_sec_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_presc_en),
    .i_clr    (w_start_play),
    .o_wrap_c (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_OVER: if (start) w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (w_wrap && w_last_sec) w_state_nxt = ST_OVER;
        else if (w_pause_req)     w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: if (w_pause_req) w_state_nxt = ST_PLAY;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered datapath outputs.
  always_comb begin
    w_score_nxt = r_score;
    w_level_nxt = r_level;
    w_timer_nxt = r_timer;
    w_tick_nxt  = 1'b0;
    if (w_start_play) begin
      w_score_nxt = '0;
      w_timer_nxt = '0;
      w_level_nxt = LVL_1;
    end else if (r_state == ST_PLAY) begin
      if (hit && (r_score < SCORE_W'(SCORE_MAX))) w_score_nxt = r_score + SCORE_W'(1);
      w_level_nxt = level_of(w_score_nxt, LVL2_SCORE, LVL3_SCORE);
      if (w_wrap) begin
        w_timer_nxt = r_timer + TIMER_W'(1);
        w_tick_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_score   <= '0;
      r_level   <= LVL_NONE;
      r_timer   <= '0;
      r_tick    <= 1'b0;
      r_playing <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_score   <= w_score_nxt;
      r_level   <= w_level_nxt;
      r_timer   <= w_timer_nxt;
      r_tick    <= w_tick_nxt;
      r_playing <= (w_state_nxt == ST_PLAY);
      r_over    <= (w_state_nxt == ST_OVER);
    end
  end

  assign score     = r_score;
  assign level     = r_level;
  assign timer     = r_timer;
  assign sec_tick  = r_tick;
  assign playing   = r_playing;
  assign game_over = r_over;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed table, hand sequences, random vs reference model.
module tb_game_round_ctrl;

  localparam int TICK_DIV   = 8;
  localparam int ROUND_SECS = 60;
  localparam int LVL2       = 10;
  localparam int LVL3       = 25;
  localparam int SMAX       = 99;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, hit, pause;
  logic [9:0] score;
  logic [1:0] level;
  logic [6:0] timer;
  logic       sec_tick, playing, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: round progress kept as elapsed PLAY cycles since start.
  bit m_active, m_paused, m_over, m_tick;
  int m_score, m_level, m_cycles;

  game_round_ctrl #(
    .TICK_DIV(TICK_DIV), .ROUND_SECS(ROUND_SECS),
    .LVL2_SCORE(LVL2), .LVL3_SCORE(LVL3), .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .pause(pause),
    .score(score), .level(level), .timer(timer),
    .sec_tick(sec_tick), .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic int lvl_for(input int s);
    if (s >= LVL3)      return 3;
    else if (s >= LVL2) return 2;
    else                return 1;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit h, input bit p);
    m_tick = 1'b0;
    if (r) begin
      m_active = 0; m_paused = 0; m_over = 0;
      m_score = 0; m_level = 0; m_cycles = 0;
    end else if (m_active) begin
      if (h) m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
      m_level = lvl_for(m_score);
      if (PAUSE_EN && p) begin
        m_active = 0; m_paused = 1;
      end else begin
        m_cycles++;
        if (m_cycles % TICK_DIV == 0) begin
          m_tick = 1'b1;
          if (m_cycles / TICK_DIV == ROUND_SECS) begin
            m_active = 0; m_over = 1;
          end
        end
      end
    end else if (m_paused) begin
      if (p) begin m_paused = 0; m_active = 1; end
    end else if (s) begin
      m_active = 1; m_over = 0; m_score = 0; m_level = 1; m_cycles = 0;
    end
  endtask

  // One clock: drive inputs, step model with them, sample outputs on the falling edge.
  task automatic drive(input bit r, input bit s, input bit h, input bit p);
    rst = r; start = s; hit = h; pause = p;
    @(posedge clk);
    model_step(r, s, h, p);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".score"},     int'(score),     m_score);
    check({tag, ".level"},     int'(level),     m_level);
    check({tag, ".timer"},     int'(timer),     m_cycles / TICK_DIV);
    check({tag, ".sec_tick"},  int'(sec_tick),  int'(m_tick));
    check({tag, ".playing"},   int'(playing),   int'(m_active));
    check({tag, ".game_over"}, int'(game_over), int'(m_over));
  endtask

  typedef struct {
    bit r, s, h, p;
    int score, level, timer;
    bit tick, play, over;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int n;
    bit seen;
    rst = 1'b1; start = 1'b0; hit = 1'b0; pause = 1'b0;

    // Start-up sequence; prescaler after each edge noted in brackets.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b1, 1'b0}; // [0]
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b1, 1'b0}; // [1]
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 1, 0, 1'b0, 1'b1, 1'b0}; // [2]
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b1, 1'b0}; // [3]
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b1, 1'b0}; // [7]
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 1, 1, 1'b1, 1'b1, 1'b0}; // wrap
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 1, 1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].p);
      check($sformatf("tbl%0d.score", i),     int'(score),     tbl[i].score);
      check($sformatf("tbl%0d.level", i),     int'(level),     tbl[i].level);
      check($sformatf("tbl%0d.timer", i),     int'(timer),     tbl[i].timer);
      check($sformatf("tbl%0d.sec_tick", i),  int'(sec_tick),  int'(tbl[i].tick));
      check($sformatf("tbl%0d.playing", i),   int'(playing),   int'(tbl[i].play));
      check($sformatf("tbl%0d.game_over", i), int'(game_over), int'(tbl[i].over));
    end

    // Idle after reset: hits ignored, everything stays zero.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, i[0], 1'b0);
      check("idle.score", int'(score), 0);
      check("idle.level", int'(level), 0);
      check("idle.state", int'({playing, game_over, sec_tick}), 0);
    end

    // Level thresholds reached on the same edge as the qualifying hit.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("lvl.score%0d", k), int'(score), k);
      check($sformatf("lvl.level%0d", k), int'(level), (k >= 25) ? 3 : (k >= 10) ? 2 : 1);
    end

    // Full round with a hit on the final-tick edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < ROUND_SECS * TICK_DIV; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_model("round");
    end
    check("end.timer_pre", int'(timer), ROUND_SECS - 1);
    check("end.playing_pre", int'(playing), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("end.game_over", int'(game_over), 1);
    check("end.timer", int'(timer), ROUND_SECS);
    check("end.score", int'(score), 1);
    check("end.sec_tick", int'(sec_tick), 1);
    check("end.playing", int'(playing), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("over.score", int'(score), 1);
    check("over.timer", int'(timer), ROUND_SECS);
    check("over.sec_tick", int'(sec_tick), 0);
    check("over.game_over", int'(game_over), 1);

    // Restart from OVER, then saturate the score.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart.score", int'(score), 0);
    check("restart.timer", int'(timer), 0);
    check("restart.level", int'(level), 1);
    check("restart.flags", int'({playing, game_over}), 2);
    for (int i = 0; i < 120; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("sat.score", int'(score), SMAX);
    check("sat.level", int'(level), 3);
    check("sat.timer", int'(timer), 120 / TICK_DIV);

`ifdef GAME_PAUSE_EN
    // Pause with prescaler at 3; resume needs 5 more edges to the next tick.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("pause.playing", int'(playing), 0);
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check("pause.hold", int'({sec_tick, playing}), 0);
    end
    check("pause.timer", int'(timer), 0);
    check("pause.score", int'(score), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("resume.playing", int'(playing), 1);
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      seen = sec_tick;
    end
    check("resume.tick_delay", n, 5);
    check("resume.timer", int'(timer), 1);
`endif

    // Randomized stimulus against the reference model.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0));
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
